// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the mips_lsu load/store unit.
package mips_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    // Lane mask in the low 2^lanes_log2 bits; the most significant of those bits is lane 0.
    function automatic logic [7:0] byte_en_mask(input lsu_size_e size,
                                                input logic [2:0] offset,
                                                input logic [1:0] lanes_log2);
        logic [7:0] base;
        logic [3:0] lanes;
        case (size)
            SZ_B:    base = 8'h80;
            SZ_H:    base = 8'hC0;
            SZ_W:    base = 8'hF0;
            SZ_D:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        lanes = 4'd1 << lanes_log2;
        return (base >> offset) >> (4'd8 - lanes);
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
interface mips_lsu_if #(
    parameter int XLEN  = 32,
    parameter int LANES = XLEN / 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_rdata;
    logic             resp_err;
    logic             mem_req;
    logic             mem_ack;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_write_en;
    logic [LANES-1:0] mem_byte_en;   // bit LANES-1 is lane 0
    logic [XLEN-1:0]  mem_data_out;  // lane 0 is the most significant byte
    logic [XLEN-1:0]  mem_data_in;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_ack, mem_data_in,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_addr, mem_write_en, mem_byte_en, mem_data_out
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_ack, mem_data_in,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_addr, mem_write_en, mem_byte_en, mem_data_out
    );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extraction/extension, misalignment.
module mips_lsu_align
    import mips_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = XLEN / 8,
    localparam int OFFW = $clog2(LANES)
) (
    input  lsu_size_e        size,
    input  logic [OFFW-1:0]  offset,
    input  logic             sign_ext,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rlanes,
    output logic [LANES-1:0] byte_en,
    output logic [XLEN-1:0]  wlanes,
    output logic [XLEN-1:0]  rdata,
    output logic             misaligned
);
    logic [OFFW-1:0] sz_m_s;
    logic [XLEN-1:0] left_s;

    // Size mask (2^size - 1) over the offset bits and the alignment check
    always_comb begin
        sz_m_s = '0;
        for (int i = 0; i < OFFW; i++) begin
            sz_m_s[i] = (size > 2'(i));
        end
        misaligned = ({1'b0, size} > 3'(OFFW)) || ((offset & sz_m_s) != '0);
        byte_en    = LANES'(byte_en_mask(size, 3'(offset), 2'(OFFW)));
    end

    // Lane i carries byte (i mod 2^size) of the big-endian store value
    always_comb begin
        wlanes = '0;
        for (int i = 0; i < LANES; i++) begin
            wlanes[XLEN-1-8*i -: 8] = wdata[{((~OFFW'(i)) & sz_m_s), 3'b000} +: 8];
        end
    end

    // Move the addressed lanes to the top, then shift down to extend
    always_comb begin
        left_s = rlanes << {offset, 3'b000};
        if (sign_ext) begin
            rdata = $signed(left_s) >>> {~sz_m_s, 3'b000};
        end else begin
            rdata = left_s >> {~sz_m_s, 3'b000};
        end
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: accepts one core request, runs one handshaked memory access, returns one response pulse.
// Build macro MIPS_LSU_TIMEOUT_EN adds an ACCESS watchdog that ends the access with an error after TIMEOUT cycles.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LANES   = XLEN / 8,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst_b,
    mips_lsu_if.slave bus
);
    localparam int OFFW = $clog2(LANES);

    if ((XLEN != 32'sd32) && (XLEN != 32'sd64)) begin : g_bad_xlen
        $fatal(1, "mips_lsu: XLEN must be 32 or 64");
    end
    if (TIMEOUT < 32'sd1) begin : g_bad_timeout
        $fatal(1, "mips_lsu: TIMEOUT must be at least 1");
    end

    lsu_state_e       state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
    logic             mem_req_q, mem_req_d;
    logic             write_q, write_d;
    logic             sext_q, sext_d;
    lsu_size_e        size_q, size_d;
    logic [OFFW-1:0]  offset_q, offset_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [LANES-1:0] byte_en_q, byte_en_d;
    logic [XLEN-1:0]  data_out_q, data_out_d;

`ifdef MIPS_LSU_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    lsu_size_e        al_size_s;
    logic [OFFW-1:0]  al_offset_s;
    logic             al_sext_s;
    logic [LANES-1:0] al_be_s;
    logic [XLEN-1:0]  al_wlanes_s;
    logic [XLEN-1:0]  al_rdata_s;
    logic             al_mis_s;

    // The align unit decodes the incoming request while idle and the latched one afterwards
    always_comb begin
        if (state_q == LSU_IDLE) begin
            al_size_s   = lsu_size_e'(bus.req_size);
            al_offset_s = bus.req_addr[OFFW-1:0];
            al_sext_s   = bus.req_signed;
        end else begin
            al_size_s   = size_q;
            al_offset_s = offset_q;
            al_sext_s   = sext_q;
        end
    end

    mips_lsu_align #(.XLEN(XLEN), .LANES(LANES)) u_align (
        .size       (al_size_s),
        .offset     (al_offset_s),
        .sign_ext   (al_sext_s),
        .wdata      (bus.req_wdata),
        .rlanes     (bus.mem_data_in),
        .byte_en    (al_be_s),
        .wlanes     (al_wlanes_s),
        .rdata      (al_rdata_s),
        .misaligned (al_mis_s)
    );

    // Next-state and next-output logic of the request FSM
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        write_d      = write_q;
        sext_d       = sext_q;
        size_d       = size_q;
        offset_d     = offset_q;
        mem_addr_d   = mem_addr_q;
        byte_en_d    = byte_en_q;
        data_out_d   = data_out_q;
`ifdef MIPS_LSU_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    write_d     = bus.req_write;
                    sext_d      = bus.req_signed;
                    size_d      = lsu_size_e'(bus.req_size);
                    offset_d    = bus.req_addr[OFFW-1:0];
                    mem_addr_d  = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    byte_en_d   = al_be_s;
                    data_out_d  = al_wlanes_s;
                    req_ready_d = 1'b0;
                    if (al_mis_s) begin
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d   = LSU_ACCESS;
                        mem_req_d = 1'b1;
`ifdef MIPS_LSU_TIMEOUT_EN
                        timer_d   = '0;
`endif
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_ACCESS: begin
                if (bus.mem_ack) begin
                    state_d      = LSU_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = write_q ? '0 : al_rdata_s;
                end
`ifdef MIPS_LSU_TIMEOUT_EN
                else if (timer_q == TO_LAST) begin
                    state_d      = LSU_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`else
                else begin
                    state_d = LSU_ACCESS;
                end
`endif
            end
            LSU_RESP: begin
                state_d      = LSU_IDLE;
                req_ready_d  = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            default: begin
                state_d      = LSU_IDLE;
                req_ready_d  = 1'b1;
                mem_req_d    = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= LSU_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            write_q      <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= SZ_B;
            offset_q     <= '0;
            mem_addr_q   <= '0;
            byte_en_q    <= '0;
            data_out_q   <= '0;
`ifdef MIPS_LSU_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            write_q      <= write_d;
            sext_q       <= sext_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            mem_addr_q   <= mem_addr_d;
            byte_en_q    <= byte_en_d;
            data_out_q   <= data_out_d;
`ifdef MIPS_LSU_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_write_en = mem_req_q & write_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_byte_en  = byte_en_q;
    assign bus.mem_data_out = data_out_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu at XLEN=32: directed requests push expected responses/memory
// accesses into queues that two monitor processes pop and compare.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    localparam int XLEN = 32;
`ifdef MIPS_LSU_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 255;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          edge_no;
        string       name;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] lanes;
        logic        we;
        string       name;
    } mem_exp_t;

    resp_exp_t resp_q[$];
    mem_exp_t  mem_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic clk = 1'b0;
    logic rst_b = 1'b0;

    mips_lsu_if #(.XLEN(XLEN)) bus ();

    mips_lsu #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    initial begin : resp_mon
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_resp: got resp_valid=1 at edge %0d expected none", edge_cnt);
                end else begin
                    r = resp_q.pop_front();
                    check({r.name, "_err"}, 32'(bus.resp_err), 32'(r.err));
                    check({r.name, "_rdata"}, bus.resp_rdata, r.rdata);
                    check({r.name, "_cycle"}, 32'(edge_cnt), 32'(r.edge_no));
                    check({r.name, "_ready_low"}, 32'(bus.req_ready), 32'd0);
                end
            end
        end
    end

    // Memory-request monitor: compares the first cycle of every access
    initial begin : mem_mon
        mem_exp_t m;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && !prev) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_mem: got mem_req=1 at edge %0d expected none", edge_cnt);
                end else begin
                    m = mem_q.pop_front();
                    check({m.name, "_addr"}, bus.mem_addr, m.addr);
                    check({m.name, "_be"}, 32'(bus.mem_byte_en), 32'(m.be));
                    check({m.name, "_we"}, 32'(bus.mem_write_en), 32'(m.we));
                    if (m.we) check({m.name, "_lanes"}, bus.mem_data_out, m.lanes);
                end
            end
            prev = bus.mem_req;
        end
    end

    // ack_k = edge after accept at which mem_ack is sampled (0 = never); exp_off = response edge offset
    task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_k,
                          input logic [31:0] mdin, input logic exp_err, input int exp_off,
                          input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_lanes);
        int acc;
        @(negedge clk);
        check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        if (!(exp_err && exp_off == 0))
            mem_q.push_back('{addr & 32'hFFFF_FFFC, exp_be, exp_lanes, wr, name});
        @(posedge clk);
        #1;
        acc = edge_cnt;
        bus.req_valid = 1'b0;
        resp_q.push_back('{exp_err, exp_rdata, acc + exp_off, name});
        if (exp_err && exp_off == 0) begin
            @(negedge clk);
            check({name, "_no_mem"}, 32'(bus.mem_req), 32'd0);
        end else if (ack_k > 0) begin
            repeat (ack_k - 1) @(posedge clk);
            @(negedge clk);
            bus.mem_ack     = 1'b1;
            bus.mem_data_in = mdin;
            @(posedge clk);
            #1;
            bus.mem_ack     = 1'b0;
            bus.mem_data_in = 32'h0;
        end
        while (edge_cnt < acc + exp_off + 2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_size    = 2'd0;
        bus.req_signed  = 1'b0;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.mem_ack     = 1'b0;
        bus.mem_data_in = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_write_en), 32'd0);
        check("rst_mem_be", 32'(bus.mem_byte_en), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_data", bus.mem_data_out, 32'h0);
        rst_b = 1'b1;

        //     name          wr    size  sg    addr          wdata         ack mem_data_in   err   off rdata         be       lanes
        do_req("sw_word",    1'b1, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF, 3, 32'h0,        1'b0, 3, 32'h0,        4'b1111, 32'hDEADBEEF);
        do_req("lb_signed",  1'b0, SZ_B, 1'b1, 32'h103, 32'h0,        1, 32'h11223380, 1'b0, 1, 32'hFFFFFF80, 4'b0001, 32'h0);
        do_req("lbu",        1'b0, SZ_B, 1'b0, 32'h103, 32'h0,        2, 32'h11223380, 1'b0, 2, 32'h00000080, 4'b0001, 32'h0);
        do_req("sh_half",    1'b1, SZ_H, 1'b0, 32'h102, 32'hAAAA1234, 1, 32'h0,        1'b0, 1, 32'h0,        4'b0011, 32'h12341234);
        do_req("lw_mis",     1'b0, SZ_W, 1'b0, 32'h101, 32'h0,        0, 32'h0,        1'b1, 0, 32'h0,        4'b0000, 32'h0);
        do_req("ld_size3",   1'b0, SZ_D, 1'b0, 32'h100, 32'h0,        0, 32'h0,        1'b1, 0, 32'h0,        4'b0000, 32'h0);
        do_req("lh_signed",  1'b0, SZ_H, 1'b1, 32'h102, 32'h0,        2, 32'h1122F0AB, 1'b0, 2, 32'hFFFFF0AB, 4'b0011, 32'h0);
        do_req("lhu",        1'b0, SZ_H, 1'b0, 32'h100, 32'h0,        1, 32'h80015566, 1'b0, 1, 32'h00008001, 4'b1100, 32'h0);
        do_req("lw_signed",  1'b0, SZ_W, 1'b1, 32'h104, 32'h0,        2, 32'h89ABCDEF, 1'b0, 2, 32'h89ABCDEF, 4'b1111, 32'h0);
        do_req("sb_byte",    1'b1, SZ_B, 1'b0, 32'h101, 32'h1234565A, 2, 32'hFFFFFFFF, 1'b0, 2, 32'h0,        4'b0100, 32'h5A5A5A5A);
        do_req("lh_mis",     1'b0, SZ_H, 1'b0, 32'h101, 32'h0,        0, 32'h0,        1'b1, 0, 32'h0,        4'b0000, 32'h0);
        do_req("lbu_lane0",  1'b0, SZ_B, 1'b0, 32'h100, 32'h0,        1, 32'hC3000000, 1'b0, 1, 32'h000000C3, 4'b1000, 32'h0);
        do_req("sd_size3",   1'b1, SZ_D, 1'b0, 32'h104, 32'h01020304, 0, 32'h0,        1'b1, 0, 32'h0,        4'b0000, 32'h0);
        do_req("sh_mis",     1'b1, SZ_H, 1'b0, 32'h103, 32'h00005678, 0, 32'h0,        1'b1, 0, 32'h0,        4'b0000, 32'h0);

        // mem_ack while idle must not produce a response or a memory access
        @(negedge clk);
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ack_ready", 32'(bus.req_ready), 32'd1);
        check("idle_ack_no_mem", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;

        // Reset during ACCESS abandons the store with no response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = SZ_W;
        bus.req_addr  = 32'h300;
        bus.req_wdata = 32'hCAFEF00D;
        mem_q.push_back('{32'h300, 4'b1111, 32'hCAFEF00D, 1'b1, "rst_store"});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_req_before", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_mem_we", 32'(bus.mem_write_en), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready_after", 32'(bus.req_ready), 32'd1);
        repeat (4) @(negedge clk);

`ifdef MIPS_LSU_TIMEOUT_EN
        do_req("to_expire",  1'b0, SZ_W, 1'b0, 32'h200, 32'h0,        0, 32'h0,        1'b1, 4, 32'h0,        4'b1111, 32'h0);
        do_req("to_ack_win", 1'b0, SZ_W, 1'b0, 32'h200, 32'h0,        4, 32'h0BADF00D, 1'b0, 4, 32'h0BADF00D, 4'b1111, 32'h0);
`endif

        for (int i = 0; i < 20 && (resp_q.size() != 0 || mem_q.size() != 0); i++) @(negedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Parametrised load/store unit between the core datapath and a variable-latency byte-lane data memory. It replaces the single-cycle, always-ready memory connection with a valid/ready request/response handshake. It supports byte, halfword, word and (at XLEN=64) doubleword accesses, with per-lane byte enables, store-data replication, load sign/zero extension and misalignment detection. The core stalls on `req_ready`/`resp_valid`; the memory side handshakes on `mem_req`/`mem_ack`.

## Interface
Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- LANES, XLEN/8, number of byte lanes. Derived; not overridden.
- TIMEOUT, 255, maximum cycles waiting for `mem_ack`. Used only with `MIPS_LSU_TIMEOUT_EN`.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of access bytes: 0 = B, 1 = H, 2 = W, 3 = D.
- req_signed  in  1  sign-extend the load result.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal size, or timeout.
- mem_req  out  1  memory access request.
- mem_ack  in  1  memory completes the access.
- mem_addr  out  XLEN  `req_addr` with the low log2(LANES) bits cleared.
- mem_write_en  out  1  equals `mem_req & latched write`.
- mem_byte_en  out  LANES  active lanes for the access.
- mem_data_out  out  [7:0] x [0:LANES-1]  store bytes.
- mem_data_in  in  [7:0] x [0:LANES-1]  load bytes.

## Operation
- Big-endian: lane 0 holds the byte at lane offset 0 and is the most significant byte.
- FSM states and transitions:
  - IDLE: `req_ready` = 1. On `req_valid`, latch the request.
    - If the request is an error, go to RESP with err = 1 and make no memory access.
    - Otherwise go to ACCESS.
  - ACCESS: `mem_req` = 1, and address, enables and data are held stable. On `mem_ack`, capture `mem_data_in` and go to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, then go to IDLE. `req_ready` = 0 in this state, so there is no back-to-back accept.
- Error conditions:
  - Size is larger than log2(LANES).
  - Address is not a multiple of 2^size.
- Byte enables, with offset = addr mod LANES: the 2^size lanes starting at that offset.
- Store data: the low 2^size bytes of `req_wdata` are replicated across all lanes in big-endian order. All lanes are driven; only the enabled lanes are meaningful.
- Load data: the enabled lanes are concatenated and then zero-extended, or sign-extended when `req_signed` = 1. For a full-width access, `req_signed` has no effect.
- `resp_rdata` is 0 for stores and for any response with `resp_err` = 1.

## Timing
- Reset values: state = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `mem_req` = 0, `mem_write_en` = 0, `mem_byte_en` = 0, `mem_addr` = 0, `mem_data_out` = 0.
- Latency, counting accept as edge 0:
  - `mem_req` is high from cycle 1.
  - `mem_ack` sampled high at edge k ≥ 1 puts `resp_valid` high in cycle k+1.
  - Minimum accept-to-response is 2 cycles.
- Error requests: `resp_valid` is high in cycle 1.
- `mem_ack` is ignored in all states except ACCESS.
- Reset asserted mid-ACCESS: `mem_req` and `mem_write_en` drop immediately, with no response. The memory must tolerate an abandoned request.
- All outputs are registered except `mem_write_en`, which is derived from registered signals.

## Configuration
- `MIPS_LSU_TIMEOUT_EN` defined:
  - An 8+-bit counter, sized for TIMEOUT, clears on entry to ACCESS and increments every ACCESS cycle without `mem_ack`.
  - When the counter reaches TIMEOUT, go to RESP with `resp_err` = 1 and drop `mem_req`.
  - If `mem_ack` and the timeout occur in the same cycle, `mem_ack` wins.
- Undefined: ACCESS waits indefinitely, and no counter logic is present.

## Structure
- Package `mips_lsu_pkg` holds:
  - the state enum (`LSU_IDLE`, `LSU_ACCESS`, `LSU_RESP`);
  - the size enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`);
  - a helper function for the byte-enable mask.
- Sub-module `mips_lsu_align` is purely combinational. It takes size, offset, signed, write data and read lanes, and produces byte enables, replicated store lanes, extended load data and the misalignment flag. The FSM and registers stay in `mips_lsu`.

## Test plan
- XLEN=32, store word 0xDEADBEEF at 0x100, ack at cycle 3:
  - `mem_byte_en` = 4'b1111;
  - lanes = DE, AD, BE, EF;
  - `resp_valid` in cycle 4 with `resp_err` = 0.
- Load byte signed at 0x103 with lane 3 = 0x80 → `resp_rdata` = 0xFFFFFF80. The same access unsigned → 0x00000080.
- Store half 0x1234 at 0x102 → `mem_byte_en` = 4'b0011, all lanes = 12, 34, 12, 34.
- Load word at 0x101 → `resp_err` = 1 in cycle 1, `mem_req` never asserted. At XLEN=32, size 3 → `resp_err` = 1.
- Reset pulsed while in ACCESS:
  - `mem_req` = 0 the same cycle;
  - `req_ready` = 1 after release;
  - no `resp_valid`.
- With `MIPS_LSU_TIMEOUT_EN` and TIMEOUT=4, no `mem_ack` → `resp_err` = 1 at the 4th wait cycle. A second run with `mem_ack` on that same cycle → normal response with `resp_err` = 0.
